// File: rtl/wr_sched_pkg.sv
// Shared types and constants for the DDR write-side burst scheduler.
// Holds the FSM encoding, fixed AXI burst attributes and channel indices.
package wr_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AW    = 3'd1,
    S_PRIME = 3'd2,
    S_W     = 3'd3,
    S_B     = 3'd4
  } state_e;

  localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int CH_CAM1   = 0;
  localparam int CH_CAM2   = 1;
  localparam int CH_FUSION = 2;
  localparam int CH_HDMI   = 3;
  localparam int CH_FOCUS  = 4;

endpackage

// File: rtl/wr_burst_scheduler_if.sv
// AXI write-channel bundle (AW, W, B) between the scheduler and the DDR controller.
interface wr_burst_scheduler_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256
);

  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [3:0]          awid;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wlast;
  logic                wready;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awvalid,
    output wdata, wstrb, wvalid, wlast, bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid, awvalid,
    input  wdata, wstrb, wvalid, wlast, bready,
    output awready, wready, bvalid
  );

endinterface

// File: rtl/wr_burst_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             valid_o
);

  logic             found_s;
  logic             take_s;
  logic [IDX_W-1:0] idx_s;

  // Rotating priority search without early exit so the loop stays a pure mux chain.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found_s   = 1'b0;
    take_s    = 1'b0;
    idx_s     = '0;
    for (int i = 0; i < N; i++) begin
      idx_s            = IDX_W'((int'(ptr_i) + i) % N);
      take_s           = req_i[idx_s] && !found_s;
      gnt_idx_o        = take_s ? idx_s : gnt_idx_o;
      gnt_oh_o[idx_s]  = take_s;
      found_s          = found_s | take_s;
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/wr_burst_scheduler.sv
// Round-robin write scheduler: fixed-length AXI bursts from per-channel line buffers
// into double-buffered DDR frame banks, exporting each channel's last finished bank.
module wr_burst_scheduler
  import wr_sched_pkg::*;
#(
  parameter int N_CH        = 5,
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 256,
  parameter int BURST_LEN   = 16,
  parameter int BUF_ADDR_W  = 5,
  parameter int CH_SHIFT    = 24,
  parameter int FRAME_SHIFT = 23,
  parameter int BEAT_INC    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_done,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH-1:0]        ch_frame_end,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  output logic [N_CH-1:0]        ch_rd_en,
  output logic [BUF_ADDR_W-1:0]  ch_rd_addr,
  output logic [N_CH-1:0]        ch_done,
  output logic [N_CH-1:0]        rd_bank,
  wr_burst_scheduler_if.master   axi
);

  localparam int CH_W     = $clog2(N_CH);
  localparam int BEAT_W   = $clog2(BURST_LEN);
  localparam int OFF_STEP = BURST_LEN * BEAT_INC;

  state_e                 state_q;
  logic [CH_W-1:0]        ptr_q;
  logic [CH_W-1:0]        gnt_idx_q;
  logic [N_CH-1:0]        gnt_oh_q;
  logic [FRAME_SHIFT-1:0] burst_cnt_q [N_CH];
  logic [N_CH-1:0]        wr_bank_q;
  logic [N_CH-1:0]        rd_bank_q;
  logic [N_CH-1:0]        pending_q;
  logic [N_CH-1:0]        done_q;
  logic [N_CH-1:0]        prime_rd_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [ADDR_W-1:0]      awaddr_q;
  logic [3:0]             awid_q;

  logic [N_CH-1:0]        arb_gnt_oh_s;
  logic [CH_W-1:0]        arb_idx_s;
  logic                   arb_valid_s;
  logic [FRAME_SHIFT-1:0] offset_d;
  logic [ADDR_W-1:0]      awaddr_d;
  logic                   w_hs_s;
  logic                   last_beat_s;
  logic [DATA_W-1:0]      ch_slice_s [N_CH];

  rr_arbiter #(.N(N_CH), .IDX_W(CH_W)) u_arb (
    .req_i     (ch_req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_gnt_oh_s),
    .gnt_idx_o (arb_idx_s),
    .valid_o   (arb_valid_s)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_slice
    assign ch_slice_s[g] = ch_data[g*DATA_W +: DATA_W];
  end

  // Burst offset is truncated to the bank size so the counter wraps inside its bank.
  always_comb begin
    offset_d = FRAME_SHIFT'(burst_cnt_q[arb_idx_s] * OFF_STEP);
    awaddr_d = (ADDR_W'(arb_idx_s) << CH_SHIFT)
             + (ADDR_W'(wr_bank_q[arb_idx_s]) << FRAME_SHIFT)
             + ADDR_W'(offset_d);
  end

  assign w_hs_s      = (state_q == S_W) && axi.wready;
  assign last_beat_s = (beat_q == BEAT_W'(BURST_LEN - 1));

  assign axi.awvalid = (state_q == S_AW);
  assign axi.awaddr  = awaddr_q;
  assign axi.awid    = awid_q;
  assign axi.awlen   = 4'(BURST_LEN - 1);
  assign axi.awsize  = AXI_SIZE_32B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wvalid  = (state_q == S_W);
  assign axi.wlast   = (state_q == S_W) && last_beat_s;
  assign axi.wdata   = (state_q == S_W) ? ch_slice_s[gnt_idx_q] : '0;
  assign axi.wstrb   = '1;
  assign axi.bready  = (state_q == S_B);

  // Read strobe follows the W handshake combinationally so a new beat is fetched every accepted cycle.
  assign ch_rd_en   = prime_rd_q | ((w_hs_s && !last_beat_s) ? gnt_oh_q : '0);
  assign ch_rd_addr = (state_q == S_W) ? (BUF_ADDR_W'(beat_q) + BUF_ADDR_W'(1)) : '0;
  assign ch_done    = done_q;
  assign rd_bank    = rd_bank_q;

  // Scheduler FSM with bank bookkeeping and registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_oh_q   <= '0;
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      pending_q  <= '0;
      done_q     <= '0;
      prime_rd_q <= '0;
      beat_q     <= '0;
      awaddr_q   <= '0;
      awid_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        burst_cnt_q[i] <= '0;
      end
    end else begin
      done_q     <= '0;
      prime_rd_q <= '0;
      pending_q  <= ((state_q == S_IDLE) ? '0 : pending_q) | ch_frame_end;
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            for (int i = 0; i < N_CH; i++) begin
              if (pending_q[i]) begin
                burst_cnt_q[i] <= '0;
                rd_bank_q[i]   <= wr_bank_q[i];
                wr_bank_q[i]   <= ~wr_bank_q[i];
              end
            end
          end else if (init_done && arb_valid_s) begin
            gnt_oh_q  <= arb_gnt_oh_s;
            gnt_idx_q <= arb_idx_s;
            awaddr_q  <= awaddr_d;
            awid_q    <= 4'(arb_idx_s);
            state_q   <= S_AW;
          end
        end
        S_AW: begin
          if (axi.awready) begin
            prime_rd_q <= gnt_oh_q;
            beat_q     <= '0;
            state_q    <= S_PRIME;
          end
        end
        S_PRIME: state_q <= S_W;
        S_W: begin
          if (axi.wready) begin
            if (last_beat_s) begin
              state_q <= S_B;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        S_B: begin
          if (axi.bvalid) begin
            done_q                 <= gnt_oh_q;
            burst_cnt_q[gnt_idx_q] <= burst_cnt_q[gnt_idx_q] + FRAME_SHIFT'(1);
            ptr_q                  <= (gnt_idx_q == CH_W'(N_CH - 1)) ? '0 : gnt_idx_q + CH_W'(1);
            state_q                <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_burst_scheduler.sv
// Bench for wr_burst_scheduler: vector table of bursts with an AXI slave and buffer model,
// plus hand sequences for frame-end ordering and asynchronous reset mid-burst.
module tb_wr_burst_scheduler;

  localparam int N_CH       = 5;
  localparam int ADDR_W     = 28;
  localparam int DATA_W     = 256;
  localparam int BURST_LEN  = 16;
  localparam int BUF_ADDR_W = 5;
  localparam int NV         = 9;

  typedef struct {
    logic [N_CH-1:0]   req;
    int                ch;
    logic [ADDR_W-1:0] addr;
    int                mode;
    logic [N_CH-1:0]   fe;
  } vec_t;

  typedef struct {
    int                ch;
    logic [ADDR_W-1:0] addr;
  } aw_exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   init_done = 1'b0;
  logic [N_CH-1:0]        ch_req = '0;
  logic [N_CH-1:0]        ch_frame_end = '0;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_rd_en;
  logic [BUF_ADDR_W-1:0]  ch_rd_addr;
  logic [N_CH-1:0]        ch_done;
  logic [N_CH-1:0]        rd_bank;

  int checks = 0;
  int errors = 0;

  vec_t              vecs [NV];
  aw_exp_t           aw_q [$];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] buf_q [N_CH];

  wr_burst_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  wr_burst_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .init_done    (init_done),
    .ch_req       (ch_req),
    .ch_frame_end (ch_frame_end),
    .ch_data      (ch_data),
    .ch_rd_en     (ch_rd_en),
    .ch_rd_addr   (ch_rd_addr),
    .ch_done      (ch_done),
    .rd_bank      (rd_bank),
    .axi          (axi)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pat(input int c, input int a);
    logic [DATA_W-1:0] v;
    v          = '0;
    v[7:0]     = 8'(a);
    v[135:128] = 8'(c);
    v[255:248] = 8'hA5 ^ 8'(a);
    return v;
  endfunction

  // Line-buffer model: one-cycle read latency, output holds without a strobe.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) buf_q[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_rd_en[c]) buf_q[c] <= pat(c, int'(ch_rd_addr));
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_buf
    assign ch_data[g*DATA_W +: DATA_W] = buf_q[g];
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_awvalid"}, axi.awvalid, 0);
    chk({tag, "_awaddr"}, axi.awaddr, 0);
    chk({tag, "_awid"}, axi.awid, 0);
    chk({tag, "_wvalid"}, axi.wvalid, 0);
    chk({tag, "_wlast"}, axi.wlast, 0);
    chk({tag, "_wdata"}, axi.wdata, 0);
    chk({tag, "_bready"}, axi.bready, 0);
    chk({tag, "_rd_en"}, ch_rd_en, 0);
    chk({tag, "_rd_addr"}, ch_rd_addr, 0);
    chk({tag, "_done"}, ch_done, 0);
    chk({tag, "_rd_bank"}, rd_bank, 0);
  endtask

  // One full burst: pops the expected AW record, fills the beat scoreboard, drives the slave.
  task automatic do_burst(input int mode, input logic [N_CH-1:0] fe);
    aw_exp_t         e;
    logic [N_CH-1:0] oh;
    int n, acc, rdc, cyc;
    e  = aw_q.pop_front();
    oh = N_CH'(1) << e.ch;
    n  = 0;
    while (!axi.awvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!axi.awvalid) begin
      checks++;
      errors++;
      $display("FAIL aw_timeout: no awvalid for channel %0d", e.ch);
      return;
    end
    chk("awid", axi.awid, e.ch);
    chk("awaddr", axi.awaddr, e.addr);
    for (int b = 0; b < BURST_LEN; b++) exp_q.push_back(pat(e.ch, b));
    @(negedge clk);
    chk("awaddr_hold", axi.awaddr, e.addr);
    axi.awready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0;
    acc = 0;
    rdc = 0;
    cyc = 0;
    while (acc < BURST_LEN && cyc < 200) begin
      axi.wready   = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      ch_frame_end = (cyc == 2) ? fe : '0;
      #1;
      if (ch_rd_en == oh) rdc++;
      else if (ch_rd_en != '0) chk("rd_en_onehot", ch_rd_en, oh);
      if (axi.wvalid && axi.wready) begin
        chk("wdata", axi.wdata, exp_q.pop_front());
        chk("wlast", axi.wlast, (acc == BURST_LEN - 1));
        acc++;
      end else if (axi.wvalid) begin
        chk("wdata_hold", axi.wdata, exp_q[0]);
        chk("wlast_hold", axi.wlast, (acc == BURST_LEN - 1));
      end
      @(negedge clk);
      cyc++;
    end
    axi.wready   = 1'b0;
    ch_frame_end = '0;
    exp_q.delete();
    chk("beats", acc, BURST_LEN);
    chk("rd_en_count", rdc, BURST_LEN);
    n = 0;
    while (!axi.bready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bready", axi.bready, 1);
    axi.bvalid = 1'b1;
    @(negedge clk);
    axi.bvalid = 1'b0;
    chk("ch_done", ch_done, oh);
  endtask

  initial begin
    int cnt, acc, n;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;

    vecs[0] = '{5'b11111, 0, 28'h0000000, 0, 5'b00000};
    vecs[1] = '{5'b11111, 1, 28'h1000000, 1, 5'b00000};
    vecs[2] = '{5'b11111, 2, 28'h2000000, 0, 5'b00000};
    vecs[3] = '{5'b11111, 3, 28'h3000000, 0, 5'b00000};
    vecs[4] = '{5'b11111, 4, 28'h4000000, 1, 5'b00000};
    vecs[5] = '{5'b11111, 0, 28'h0000080, 0, 5'b00000};
    vecs[6] = '{5'b11111, 1, 28'h1000080, 0, 5'b00000};
    vecs[7] = '{5'b11111, 2, 28'h2000080, 0, 5'b00100};
    vecs[8] = '{5'b00100, 2, 28'h2800000, 0, 5'b00000};

    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    chk("awlen", axi.awlen, 15);
    chk("awsize", axi.awsize, 5);
    chk("awburst", axi.awburst, 1);

    @(negedge clk);
    rst    = 1'b1;
    ch_req = 5'b11111;
    cnt    = 0;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (axi.awvalid) cnt++;
    end
    chk("no_aw_before_init", cnt, 0);
    @(negedge clk);
    init_done = 1'b1;

    for (int i = 0; i < NV; i++) begin
      ch_req = vecs[i].req;
      aw_q.push_back('{vecs[i].ch, vecs[i].addr});
      do_burst(vecs[i].mode, vecs[i].fe);
    end
    chk("rd_bank_after_fe2", rd_bank, 5'b00000);

    // Frame-end pending and a request meet in the same IDLE cycle.
    ch_req       = '0;
    ch_frame_end = 5'b01100;
    @(negedge clk);
    ch_frame_end = '0;
    ch_req       = 5'b01000;
    @(negedge clk);
    chk("grant_deferred", axi.awvalid, 0);
    chk("rd_bank_applied", rd_bank, 5'b00100);
    @(negedge clk);
    chk("grant_after_fe", axi.awvalid, 1);
    ch_req = '0;
    aw_q.push_back('{3, 28'h3800000});
    do_burst(0, '0);

    // Asynchronous reset while the W phase sits at beat 7.
    ch_req = 5'b00010;
    n = 0;
    while (!axi.awvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_awaddr", axi.awaddr, 28'h1000100);
    axi.awready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0;
    ch_req      = '0;
    axi.wready  = 1'b1;
    acc = 0;
    n   = 0;
    while (acc < 7 && n < 50) begin
      #1;
      if (axi.wvalid && axi.wready) acc++;
      @(negedge clk);
      n++;
    end
    chk("pre_rst_wvalid", axi.wvalid, 1);
    chk("pre_rst_rd_addr", ch_rd_addr, 8);
    rst        = 1'b0;
    axi.wready = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst    = 1'b1;
    ch_req = 5'b11111;
    aw_q.delete();
    aw_q.push_back('{0, 28'h0000000});
    do_burst(0, '0);
    ch_req = '0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
